// File: rtl/axi_port_arbiter_pkg.sv
// Shared encodings for the AXI port arbiter: access sizes, response codes,
// request direction and grant state.
package axi_port_arbiter_pkg;

  // AXI access size codes (bytes = 1 << size)
  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } axi_size_e;

  // AXI response codes
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

  // Request direction on the shared port
  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } axi_req_e;

  // Arbiter grant state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GNT_MEM = 2'd1,
    ST_GNT_IF  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_port_arbiter.sv
// Shares the single AXI master port between instruction fetch (IF) and data
// memory (MEM). MEM has fixed priority over IF, with a starvation guard that
// forces an IF grant after MAX_CONSEC back-to-back MEM grants while IF waits.
// One transaction is outstanding at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_*                IF requester (read-only), ready is a 1-cycle pulse
//   mem_*               MEM requester (read/write), ready is a 1-cycle pulse
//   axi_*               single-requester interface to the AXI bridge
module axi_port_arbiter
  import axi_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic [1:0]        if_size_i,
  output logic              if_ready_o,
  output logic [DATA_W-1:0] if_data_o,
  output logic [1:0]        if_resp_o,
  input  logic              mem_valid_i,
  input  logic              mem_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [7:0]        mem_wmask_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic [1:0]        mem_resp_o,
  output logic              axi_valid_o,
  output logic              axi_req_o,
  output logic [ADDR_W-1:0] axi_addr_o,
  output logic [1:0]        axi_size_o,
  output logic [DATA_W-1:0] axi_wdata_o,
  output logic [7:0]        axi_wmask_o,
  input  logic              axi_ready_i,
  input  logic [DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]        axi_resp_i
);

  localparam int unsigned CNT_W = $clog2(MAX_CONSEC + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  consec_q, consec_d;
  logic              drop_q, drop_d;
  logic              axi_valid_q, axi_valid_d;
  logic              axi_req_q, axi_req_d;
  logic [ADDR_W-1:0] axi_addr_q, axi_addr_d;
  logic [1:0]        axi_size_q, axi_size_d;
  logic [DATA_W-1:0] axi_wdata_q, axi_wdata_d;
  logic [7:0]        axi_wmask_q, axi_wmask_d;

  logic if_starved_c;
  logic mem_win_c;

  assign if_starved_c = if_valid_i && (consec_q == CNT_W'(MAX_CONSEC));
  assign mem_win_c    = mem_valid_i && !if_starved_c;

  // State and latched request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      consec_q    <= '0;
      drop_q      <= 1'b0;
      axi_valid_q <= 1'b0;
      axi_req_q   <= 1'b0;
      axi_addr_q  <= '0;
      axi_size_q  <= '0;
      axi_wdata_q <= '0;
      axi_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      consec_q    <= consec_d;
      drop_q      <= drop_d;
      axi_valid_q <= axi_valid_d;
      axi_req_q   <= axi_req_d;
      axi_addr_q  <= axi_addr_d;
      axi_size_q  <= axi_size_d;
      axi_wdata_q <= axi_wdata_d;
      axi_wmask_q <= axi_wmask_d;
    end
  end

  // Next-state, grant latching, starvation counter and flush tracking
  always_comb begin
    state_d     = state_q;
    consec_d    = consec_q;
    drop_d      = drop_q;
    axi_valid_d = axi_valid_q;
    axi_req_d   = axi_req_q;
    axi_addr_d  = axi_addr_q;
    axi_size_d  = axi_size_q;
    axi_wdata_d = axi_wdata_q;
    axi_wmask_d = axi_wmask_q;

    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (mem_win_c) begin
          state_d     = ST_GNT_MEM;
          axi_valid_d = 1'b1;
          axi_req_d   = mem_req_i;
          axi_addr_d  = mem_addr_i;
          axi_size_d  = mem_size_i;
          axi_wdata_d = mem_wdata_i;
          axi_wmask_d = mem_wmask_i;
          if (if_valid_i && (consec_q != CNT_W'(MAX_CONSEC))) begin
            consec_d = consec_q + CNT_W'(1);
          end
        end else if (if_valid_i) begin
          state_d     = ST_GNT_IF;
          consec_d    = '0;
          axi_valid_d = 1'b1;
          axi_req_d   = REQ_READ;
          axi_addr_d  = if_addr_i;
          axi_size_d  = if_size_i;
          axi_wdata_d = '0;
          axi_wmask_d = '0;
        end
      end
      ST_GNT_MEM, ST_GNT_IF: begin
        // A requester that withdraws mid-transfer has been flushed; the bus
        // transfer still runs to completion but its response is discarded.
        if ((state_q == ST_GNT_MEM && !mem_valid_i) ||
            (state_q == ST_GNT_IF && !if_valid_i)) begin
          drop_d = 1'b1;
        end
        if (axi_ready_i) begin
          state_d     = ST_IDLE;
          axi_valid_d = 1'b0;
          drop_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starvation only accrues while IF is actually waiting
    if (!if_valid_i) begin
      consec_d = '0;
    end
  end

  // Completion is returned combinationally to the owning requester only
  assign if_ready_o  = axi_ready_i && (state_q == ST_GNT_IF) && !drop_q;
  assign mem_ready_o = axi_ready_i && (state_q == ST_GNT_MEM) && !drop_q;
  assign if_data_o   = if_ready_o  ? axi_rdata_i : '0;
  assign if_resp_o   = if_ready_o  ? axi_resp_i  : '0;
  assign mem_rdata_o = mem_ready_o ? axi_rdata_i : '0;
  assign mem_resp_o  = mem_ready_o ? axi_resp_i  : '0;

  assign axi_valid_o = axi_valid_q;
  assign axi_req_o   = axi_req_q;
  assign axi_addr_o  = axi_addr_q;
  assign axi_size_o  = axi_size_q;
  assign axi_wdata_o = axi_wdata_q;
  assign axi_wmask_o = axi_wmask_q;

endmodule
